matrix_stream_loader: RTL
=========================

# matrix_stream_loader

Byte-stream front/back end for the `systemizer` matrix core. The loader accepts the matrix as an 8-bit valid/ready stream and unpacks each byte into BLOCK-bit words written sequentially into the systemizer's matrix memory. It then pulses `start`, waits for `done`, and on success reads the reduced matrix back through the same memory and returns it as an 8-bit valid/ready stream. It sits between the chip pins (`ui_in`/`uo_out` level) and the systemizer plus its matrix RAM.

## Interface
- `BLOCK`, 4: memory word width in bits; legal values are 1, 2, 4, 8.
- `WORDS`, 20: words per matrix (L·K/BLOCK; 8·10/4 = 20 by default). Must be a multiple of 8/BLOCK.
- `AW`, `clog2(WORDS)`: width of the memory address.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  matrix byte; word 0 of each byte is in the LSBs.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `out_data`  out  8  result byte, packed the same way as `in_data`.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts `out_data`.
- `wr_en`  out  1  matrix memory write strobe.
- `wr_addr`  out  AW  write address.
- `wr_data`  out  BLOCK  write word.
- `rd_en`  out  1  matrix memory read strobe.
- `rd_addr`  out  AW  read address.
- `rd_data`  in  BLOCK  read word, valid exactly 1 cycle after `rd_en`.
- `start`  out  1  one-cycle pulse that launches the systemizer.
- `sys_done`  in  1  systemizer finished.
- `sys_fail`  in  1  matrix not systematic; qualified by `sys_done`.
- `busy`  out  1  high in every state except LOAD.
- `fail`  out  1  sticky; set when a run fails, cleared by the first accepted byte of the next matrix.

## Operation
- **Reset.** All outputs are 0, all counters are 0, and state is LOAD. `in_ready` rises in the first cycle after `rst_n` deasserts.
- **LOAD.** `in_ready`=1. On `in_valid & in_ready`, the byte is captured into a shift register, `fail` is cleared if this is byte 0 of the matrix, and the state goes to WRITE.
- **WRITE.** `in_ready`=0. One word is written per cycle, 8/BLOCK cycles in total.
  - `wr_data` = shift register [BLOCK-1:0]; the register shifts right by BLOCK each cycle.
  - `wr_addr` increments after each write.
  - After the final word of the byte: if `wr_addr` has reached WORDS, go to KICK; otherwise go to LOAD.
- **KICK.** `start`=1 for exactly one cycle, then the state goes to RUN. The write address resets to 0.
- **RUN.** Wait for `sys_done`.
  - `sys_done & sys_fail`: set `fail`, go to LOAD, produce no output.
  - `sys_done & !sys_fail`: go to READ.
  - `sys_done` in any state other than RUN is ignored.
- **READ.** Issue 8/BLOCK reads on consecutive cycles, `rd_addr` incrementing.
  - Each `rd_data` is placed into `out_data` at bit position BLOCK·i.
  - The cycle after the last `rd_data` arrives, the state goes to SEND.
- **SEND.** `out_valid`=1, and `out_data` stays stable until `out_ready`.
  - On handshake, if `rd_addr` equals WORDS, reset the read address and go to LOAD; otherwise go back to READ.

## Timing
- **Byte intake.** Throughput is 1 byte per 1+8/BLOCK cycles (3 cycles at BLOCK=4). The first `wr_en` for a byte comes 1 cycle after the accepting edge.
- **Start.** `start` is asserted 1 cycle after the last `wr_en`.
- **Readout.** The first `rd_en` comes 1 cycle after `sys_done` is sampled. `out_valid` rises 8/BLOCK+1 cycles after the first `rd_en` of the byte.
- **Backpressure.** `out_ready` low holds SEND indefinitely. No read is issued while in SEND.
- **Valid/ready rules.** `out_valid` never drops without a handshake. `in_ready` does not depend combinationally on `in_valid`.
- **Mid-operation reset.** Asserting `rst_n` low in any state returns the block to reset values immediately (asynchronously). Partial bytes and partial words are discarded. `start`, `wr_en` and `rd_en` are forced low.
- **Address range.** Addresses never exceed WORDS-1. There is no wrap-around during a single pass.

## Test plan
- **Load and start.** BLOCK=4, WORDS=20. Stream bytes 0x10..0x19, one per cycle, with `in_valid` held high.
  - Expect 20 writes: addr 0 data 0x0, addr 1 data 0x1, addr 2 data 0x1, and so on.
  - Expect `in_ready` high only 1 cycle in every 3.
  - Expect a single `start` pulse 1 cycle after the write to addr 19.
- **Success readout.** The memory model returns word = addr & 0xF. Pulse `sys_done` with `sys_fail`=0.
  - Expect 10 output bytes 0x10, 0x32, 0x54, 0x76, 0x98, 0xBA, 0xDC, 0xFE, 0x10, 0x32.
  - Expect `busy` to fall after the last handshake.
- **Failure.** After loading, pulse `sys_done` with `sys_fail`=1.
  - Expect `fail`=1, no `out_valid`, and `in_ready`=1 on the next cycle.
  - Expect `fail` to clear on the next accepted byte.
- **Backpressure.** Hold `out_ready`=0 for 7 cycles on byte 3.
  - Expect `out_data` stable, no `rd_en` during the stall, and no bytes lost or duplicated.
- **Spurious done.** Pulse `sys_done` during LOAD and during WRITE. Expect no state change and no output.
- **Reset mid-WRITE.** Assert `rst_n` low after 5 bytes.
  - Expect all outputs 0 immediately.
  - On restart, the first write goes to addr 0.

Source files
------------

// File: rtl/matrix_stream_loader.sv
// Byte-stream loader/unloader around the systemizer: unpacks bytes into BLOCK-bit RAM words, kicks the core, streams the result back.
// Latency: first wr_en 1 cycle after byte accept, start 1 cycle after last write, out_valid 8/BLOCK+1 cycles after first rd_en.
// Backpressure: in_ready is registered (1 byte per 1+8/BLOCK cycles); out_ready low parks SEND with no reads issued.
module matrix_stream_loader #(
    parameter int BLOCK = 4,
    parameter int WORDS = 20,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [BLOCK-1:0] wr_data,
    output logic             rd_en,
    output logic [AW-1:0]    rd_addr,
    input  logic [BLOCK-1:0] rd_data,
    output logic             start,
    input  logic             sys_done,
    input  logic             sys_fail,
    output logic             busy,
    output logic             fail
);
    localparam int NW = 8 / BLOCK;
    localparam int CW = $clog2(NW + 1);

    localparam logic [CW-1:0] LAST_W = CW'(NW - 1);
    localparam logic [CW-1:0] ALL_R  = CW'(NW);
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [AW:0]   END_A  = (AW+1)'(WORDS);
    localparam logic [AW:0]   ONE_A  = (AW+1)'(1);

    localparam logic [2:0] S_LOAD  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_KICK  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;
    localparam logic [2:0] S_SEND  = 3'd5;

    logic [2:0]    r_state;
    logic [7:0]    r_shift;
    logic [CW-1:0] r_wcnt;
    logic [CW-1:0] r_rcnt;
    logic [CW-1:0] r_cap_idx;
    logic          r_cap_vld;
    logic [AW:0]   r_waddr;
    logic [AW:0]   r_raddr;
    logic          r_in_ready;
    logic          r_fail;
    logic [7:0]    r_out_data;

    logic          w_accept;
    logic          w_wr;
    logic          w_rd;
    logic [AW:0]   w_waddr_nxt;

    // Address counters carry one extra bit so they can reach WORDS; the
    // ports only ever show them while the matching strobe is high.
    assign w_accept    = (r_state == S_LOAD) && r_in_ready && in_valid;
    assign w_wr        = (r_state == S_WRITE);
    assign w_rd        = (r_state == S_READ) && (r_rcnt != ALL_R);
    assign w_waddr_nxt = r_waddr + ONE_A;

    assign in_ready  = r_in_ready;
    assign wr_en     = w_wr;
    assign wr_addr   = w_wr ? r_waddr[AW-1:0] : '0;
    assign wr_data   = w_wr ? r_shift[BLOCK-1:0] : '0;
    assign rd_en     = w_rd;
    assign rd_addr   = w_rd ? r_raddr[AW-1:0] : '0;
    assign start     = (r_state == S_KICK);
    assign out_valid = (r_state == S_SEND);
    assign out_data  = r_out_data;
    assign busy      = (r_state != S_LOAD);
    assign fail      = r_fail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_LOAD;
            r_shift    <= '0;
            r_wcnt     <= '0;
            r_rcnt     <= '0;
            r_waddr    <= '0;
            r_raddr    <= '0;
            r_in_ready <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_in_ready <= ~w_accept;
                    if (w_accept) begin
                        r_shift <= in_data;
                        r_wcnt  <= '0;
                        if (r_waddr == '0) begin
                            r_fail <= 1'b0;
                        end
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_shift <= r_shift >> BLOCK;
                    r_waddr <= w_waddr_nxt;
                    r_wcnt  <= r_wcnt + ONE_C;
                    if (r_wcnt == LAST_W) begin
                        if (w_waddr_nxt == END_A) begin
                            r_state <= S_KICK;
                        end else begin
                            r_state    <= S_LOAD;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                S_KICK: begin
                    r_waddr <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (sys_done) begin
                        if (sys_fail) begin
                            r_fail     <= 1'b1;
                            r_state    <= S_LOAD;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_rcnt  <= '0;
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    // One trailing cycle after the last read lets its data land.
                    if (w_rd) begin
                        r_raddr <= r_raddr + ONE_A;
                        r_rcnt  <= r_rcnt + ONE_C;
                    end else begin
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (r_raddr == END_A) begin
                            r_raddr    <= '0;
                            r_state    <= S_LOAD;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_rcnt  <= '0;
                            r_state <= S_READ;
                        end
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_vld  <= 1'b0;
            r_cap_idx  <= '0;
            r_out_data <= '0;
        end else begin
            r_cap_vld <= w_rd;
            r_cap_idx <= r_rcnt;
            if (r_cap_vld) begin
                r_out_data[r_cap_idx*BLOCK +: BLOCK] <= rd_data;
            end
        end
    end

endmodule
